// File: rtl/write_sector_sequencer_pkg.sv
// Shared constants for the write-sector sequencer: FSM state codes and abort causes.
package wsq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_HUNT  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ABORT = 3'd5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_GATE    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_SYNC    = 2'd3;

endpackage

// File: rtl/write_sector_sequencer_if.sv
// Drive-side, separator and sector-buffer signals of the write-sector sequencer.
interface write_sector_sequencer_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  wr_gate;
    logic [ADDR_WIDTH-1:0] sector_len;
    logic                  sep_en;
    logic                  sep_clock;
    logic                  sep_data;
    logic                  buf_we;
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [7:0]            buf_wdata;
    logic                  busy;
    logic                  sector_done;
    logic                  err;
    logic [1:0]            err_code;

    modport master (
        output wr_gate, sector_len, sep_clock, sep_data,
        input  sep_en, buf_we, buf_addr, buf_wdata, busy, sector_done, err, err_code
    );

    modport slave (
        input  wr_gate, sector_len, sep_clock, sep_data,
        output sep_en, buf_we, buf_addr, buf_wdata, busy, sector_done, err, err_code
    );
endinterface

// File: rtl/write_sector_sequencer_sync_2ff.sv
// Reusable two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/write_sector_sequencer.sv
// Write-sector sequencer: arms the data separator on write gate, hunts the sync mark,
// then packs separated bits MSB-first into bytes written to the sector buffer.
module write_sector_sequencer
    import wsq_pkg::*;
#(
    parameter int GATE_SETTLE  = 4,
    parameter int PREAMBLE_MIN = 8,
    parameter int ADDR_WIDTH   = 9,
    parameter int BIT_TIMEOUT  = 64
) (
    input logic                     hf_clk,
    input logic                     rst,
    write_sector_sequencer_if.slave bus
);
    localparam int SW = $clog2(GATE_SETTLE + 1);
    localparam int ZW = $clog2(PREAMBLE_MIN + 1);
    localparam int TW = $clog2(BIT_TIMEOUT);
    localparam int BW = ADDR_WIDTH + 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(GATE_SETTLE - 1);
    localparam logic [ZW-1:0] ZERO_MIN    = ZW'(PREAMBLE_MIN);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(BIT_TIMEOUT - 1);

    logic                  gate_s;
    logic                  gate_q, gate_d;
    logic                  sep_clock_q, sep_clock_d;
    logic [2:0]            state_q, state_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic [ZW-1:0]         zero_q, zero_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            shift_q, shift_d;
    logic [BW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic                  buf_we_q, buf_we_d;
    logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]            buf_wdata_q, buf_wdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  bit_evt;
    logic                  timeout;
    logic                  byte_done;

    sync_2ff u_gate_sync (
        .clk (hf_clk),
        .rst (rst),
        .d   (bus.wr_gate),
        .q   (gate_s)
    );

    assign bit_evt = bus.sep_clock & ~sep_clock_q;
    assign timeout = ~bit_evt && (timer_q == TIMER_LAST);

    always_comb begin
        gate_d      = gate_s;
        sep_clock_d = bus.sep_clock;
        state_d     = state_q;
        settle_d    = settle_q;
        zero_d      = zero_q;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        len_d       = len_q;
        buf_we_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        byte_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gate_s && !gate_q) begin
                    state_d    = ST_ARM;
                    settle_d   = '0;
                    err_code_d = ERR_NONE;
                end
            end
            ST_ARM: begin
                len_d      = bus.sector_len;
                zero_d     = '0;
                timer_d    = '0;
                bit_cnt_d  = '0;
                shift_d    = '0;
                byte_cnt_d = '0;
                if (!gate_s) begin
                    state_d    = ST_ABORT;
                    err_d      = 1'b1;
                    err_code_d = ERR_GATE;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = ST_HUNT;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_HUNT: begin
                timer_d = bit_evt ? '0 : timer_q + 1'b1;
                // A gate drop before a full preamble was seen is reported as lost sync.
                if (!gate_s) begin
                    state_d    = ST_ABORT;
                    err_d      = 1'b1;
                    err_code_d = (zero_q < ZERO_MIN) ? ERR_SYNC : ERR_GATE;
                end else if (timeout) begin
                    state_d    = ST_ABORT;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else if (bit_evt) begin
                    if (!bus.sep_data) begin
                        if (zero_q < ZERO_MIN) begin
                            zero_d = zero_q + 1'b1;
                        end
                    end else if (zero_q >= ZERO_MIN) begin
                        state_d = ST_DATA;
                    end else begin
                        zero_d = '0;
                    end
                end
            end
            ST_DATA: begin
                timer_d = bit_evt ? '0 : timer_q + 1'b1;
                if (bit_evt) begin
                    shift_d = {shift_q[5:0], bus.sep_data};
                    if (bit_cnt_q == 3'd7) begin
                        buf_we_d    = 1'b1;
                        buf_addr_d  = byte_cnt_q[ADDR_WIDTH-1:0];
                        buf_wdata_d = {shift_q, bus.sep_data};
                        byte_cnt_d  = byte_cnt_q + 1'b1;
                        bit_cnt_d   = '0;
                        byte_done   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                // A byte completed on the gate-drop cycle is still written before aborting.
                if (!gate_s) begin
                    state_d    = ST_ABORT;
                    err_d      = 1'b1;
                    err_code_d = ERR_GATE;
                end else if (timeout) begin
                    state_d    = ST_ABORT;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else if (byte_done && (byte_cnt_q == {1'b0, len_q})) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                if (!gate_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                if (!gate_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hf_clk) begin
        if (rst) begin
            gate_q      <= 1'b0;
            sep_clock_q <= 1'b0;
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            zero_q      <= '0;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            len_q       <= '0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            gate_q      <= gate_d;
            sep_clock_q <= sep_clock_d;
            state_q     <= state_d;
            settle_q    <= settle_d;
            zero_q      <= zero_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            len_q       <= len_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.sep_en      = (state_q == ST_HUNT) || (state_q == ST_DATA);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.buf_we      = buf_we_q;
    assign bus.buf_addr    = buf_addr_q;
    assign bus.buf_wdata   = buf_wdata_q;
    assign bus.sector_done = done_q;
    assign bus.err         = err_q;
    assign bus.err_code    = err_code_q;
endmodule

// File: tb/tb_write_sector_sequencer.sv
// Self-checking bench: table-driven sector scenarios, hand-written corner sequences and
// randomized sectors compared against a bit-stream-level reference model.
module tb_write_sector_sequencer;
    import wsq_pkg::*;

    localparam int AW   = 9;
    localparam int PMIN = 8;

    typedef struct {
        int          len;
        int          fake_zeros;
        int          pre_zeros;
        int          sync;
        int          nbytes;
        logic [31:0] data;
        int          drop_at;
        int          gap;
        int          exp_wr;
        int          exp_done;
        int          exp_code;
    } vec_t;

    logic hf_clk = 1'b0;
    logic rst;

    write_sector_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    write_sector_sequencer #(
        .GATE_SETTLE  (4),
        .PREAMBLE_MIN (PMIN),
        .ADDR_WIDTH   (AW),
        .BIT_TIMEOUT  (64)
    ) dut (
        .hf_clk (hf_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 hf_clk = ~hf_clk;

    int              checks   = 0;
    int              failures = 0;
    vec_t            vecs[8];
    bit              bits_q[$];
    logic [7:0]      exp_bytes[$];
    logic [AW-1:0]   wr_addr_q[$];
    logic [7:0]      wr_data_q[$];
    int              done_cnt;
    int              err_cnt;
    int              m_done;
    int              m_code;
    logic [AW-1:0]   cur_len;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Every observed write and pulse is logged here; scenarios compare the logs afterwards.
    always @(negedge hf_clk) begin
        if (bus.buf_we === 1'b1) begin
            wr_addr_q.push_back(bus.buf_addr);
            wr_data_q.push_back(bus.buf_wdata);
            check_output("addr_bound", 32'(bus.buf_addr <= cur_len), 32'd1);
        end
        if (bus.sector_done === 1'b1) done_cnt++;
        if (bus.err === 1'b1) begin
            err_cnt++;
            check_output("abort_sep_en", 32'(bus.sep_en), 32'd0);
        end
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_ctrl"}, 32'({bus.busy, bus.sep_en, bus.buf_we, bus.sector_done, bus.err}), 32'd0);
        check_output({tag, "_code"}, 32'(bus.err_code), 32'd0);
        check_output({tag, "_bus"}, 32'({bus.buf_addr, bus.buf_wdata}), 32'd0);
    endtask

    task automatic send_bit(input bit b);
        bus.sep_data  = b;
        bus.sep_clock = 1'b1;
        repeat (2) @(negedge hf_clk);
        bus.sep_clock = 1'b0;
        repeat (2) @(negedge hf_clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) bits_q.push_back(b[k]);
    endtask

    task automatic wait_sep_en();
        int waited;
        waited = 0;
        while (bus.sep_en !== 1'b1 && waited < 50) begin
            @(negedge hf_clk);
            waited++;
        end
        check_output("sep_en_rise", 32'(bus.sep_en), 32'd1);
    endtask

    // Reference: find the sync bit from zero-run lengths, then cut the rest into MSB-first bytes.
    task automatic ref_model(input int len, input int drop_at);
        int n;
        int run;
        int sync_at;
        int avail;
        int nbytes;
        int acc;
        n       = (drop_at < 0) ? bits_q.size() : drop_at;
        run     = 0;
        sync_at = -1;
        exp_bytes.delete();
        for (int i = 0; i < n && sync_at < 0; i++) begin
            if (bits_q[i] == 1'b0) run++;
            else if (run >= PMIN) sync_at = i;
            else run = 0;
        end
        if (sync_at < 0) begin
            m_done = 0;
            m_code = (drop_at < 0) ? int'(ERR_TIMEOUT) : ((run < PMIN) ? int'(ERR_SYNC) : int'(ERR_GATE));
        end else begin
            avail  = (n - sync_at - 1) / 8;
            nbytes = (avail > len) ? len + 1 : avail;
            for (int b = 0; b < nbytes; b++) begin
                acc = 0;
                for (int k = 0; k < 8; k++) acc = acc * 2 + int'(bits_q[sync_at + 1 + 8 * b + k]);
                exp_bytes.push_back(8'(acc));
            end
            if (nbytes == len + 1) begin
                m_done = 1;
                m_code = int'(ERR_NONE);
            end else begin
                m_done = 0;
                m_code = (drop_at < 0) ? int'(ERR_TIMEOUT) : int'(ERR_GATE);
            end
        end
    endtask

    task automatic apply_stimulus(input int len, input int drop_at, input int gap);
        int waited;
        clear_logs();
        cur_len        = len[AW-1:0];
        bus.sector_len = cur_len;
        bus.wr_gate    = 1'b1;
        wait_sep_en();
        repeat (gap) @(negedge hf_clk);
        for (int i = 0; i < bits_q.size(); i++) begin
            if (i == drop_at) break;
            send_bit(bits_q[i]);
        end
        if (drop_at >= 0) begin
            bus.wr_gate = 1'b0;
        end else begin
            waited = 0;
            while (done_cnt == 0 && err_cnt == 0 && waited < 300) begin
                @(negedge hf_clk);
                waited++;
            end
            if (err_cnt != 0) check_output("timeout_window", 32'((waited >= 56) && (waited <= 68)), 32'd1);
            bus.wr_gate = 1'b0;
        end
        repeat (8) @(negedge hf_clk);
        check_output("idle_busy", 32'(bus.busy), 32'd0);
        check_output("idle_sep_en", 32'(bus.sep_en), 32'd0);
    endtask

    task automatic compare_logs(input string tag, input int exp_done, input int exp_code);
        check_output({tag, "_writes"}, 32'(wr_data_q.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < wr_data_q.size(); i++) begin
            check_output({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(i));
            check_output({tag, "_data"}, 32'(wr_data_q[i]), 32'(exp_bytes[i]));
        end
        check_output({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
        check_output({tag, "_errs"}, 32'(err_cnt), (exp_code != 0) ? 32'd1 : 32'd0);
        check_output({tag, "_code"}, 32'(bus.err_code), 32'(exp_code));
    endtask

    task automatic run_vector(input int idx);
        vec_t       v;
        logic [7:0] b;
        v = vecs[idx];
        bits_q.delete();
        exp_bytes.delete();
        if (v.fake_zeros >= 0) begin
            repeat (v.fake_zeros) bits_q.push_back(1'b0);
            bits_q.push_back(1'b1);
        end
        repeat (v.pre_zeros) bits_q.push_back(1'b0);
        if (v.sync != 0) bits_q.push_back(1'b1);
        for (int i = 0; i < v.nbytes; i++) begin
            b = v.data[31 - 8 * i -: 8];
            push_byte(b);
            if (i < v.exp_wr) exp_bytes.push_back(b);
        end
        apply_stimulus(v.len, v.drop_at, v.gap);
        compare_logs($sformatf("vec%0d", idx), v.exp_done, v.exp_code);
    endtask

    initial begin
        #800000;
        checks++;
        failures++;
        $display("[TB] FAIL watchdog actual=still_running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int len;
        int drop;
        //          len fake pre sync nb  data          drop gap wr done code
        vecs[0] = '{3, -1, 10, 1, 4, 32'hA53CFF00, -1,  0, 4, 1, int'(ERR_NONE)};
        vecs[1] = '{0,  5, 10, 1, 1, 32'h81000000, -1,  0, 1, 1, int'(ERR_NONE)};
        vecs[2] = '{3, -1, 10, 1, 4, 32'hA53CFF00, 23,  0, 1, 0, int'(ERR_GATE)};
        vecs[3] = '{3, -1,  0, 0, 0, 32'h00000000, -1,  0, 0, 0, int'(ERR_TIMEOUT)};
        vecs[4] = '{0,  7,  8, 1, 1, 32'h5A000000, -1,  0, 1, 1, int'(ERR_NONE)};
        vecs[5] = '{2, -1,  5, 0, 0, 32'h00000000,  5,  0, 0, 0, int'(ERR_SYNC)};
        vecs[6] = '{2, -1,  9, 0, 0, 32'h00000000,  9,  0, 0, 0, int'(ERR_GATE)};
        vecs[7] = '{1, -1,  8, 1, 2, 32'hC37E0000, -1, 58, 2, 1, int'(ERR_NONE)};

        rst            = 1'b1;
        bus.wr_gate    = 1'b0;
        bus.sector_len = '0;
        bus.sep_clock  = 1'b0;
        bus.sep_data   = 1'b0;
        cur_len        = '0;
        clear_logs();
        repeat (3) @(negedge hf_clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge hf_clk);

        for (int i = 0; i < 8; i++) run_vector(i);

        // Reset in the middle of the second data byte, then a clean nominal sector.
        clear_logs();
        bits_q.delete();
        repeat (10) bits_q.push_back(1'b0);
        bits_q.push_back(1'b1);
        push_byte(8'hA5);
        push_byte(8'h3C);
        cur_len        = 9'd3;
        bus.sector_len = 9'd3;
        bus.wr_gate    = 1'b1;
        wait_sep_en();
        for (int i = 0; i < 23; i++) send_bit(bits_q[i]);
        rst = 1'b1;
        @(negedge hf_clk);
        check_all_zero("mid_rst");
        bus.wr_gate = 1'b0;
        repeat (2) @(negedge hf_clk);
        rst = 1'b0;
        repeat (6) @(negedge hf_clk);
        check_output("mid_rst_errs", 32'(err_cnt), 32'd0);
        check_output("mid_rst_done", 32'(done_cnt), 32'd0);
        check_output("mid_rst_writes", 32'(wr_data_q.size()), 32'd1);
        run_vector(0);

        // Gate falls (after synchronization) on the very cycle of the final byte's last bit.
        clear_logs();
        bits_q.delete();
        repeat (10) bits_q.push_back(1'b0);
        bits_q.push_back(1'b1);
        push_byte(8'h12);
        push_byte(8'h34);
        cur_len        = 9'd1;
        bus.sector_len = 9'd1;
        bus.wr_gate    = 1'b1;
        wait_sep_en();
        for (int i = 0; i < bits_q.size() - 1; i++) send_bit(bits_q[i]);
        bus.wr_gate = 1'b0;
        repeat (2) @(negedge hf_clk);
        send_bit(bits_q[bits_q.size() - 1]);
        repeat (8) @(negedge hf_clk);
        exp_bytes.delete();
        exp_bytes.push_back(8'h12);
        exp_bytes.push_back(8'h34);
        compare_logs("gate_last_bit", 0, int'(ERR_GATE));

        // Full-size sector with a counting pattern.
        bits_q.delete();
        repeat (10) bits_q.push_back(1'b0);
        bits_q.push_back(1'b1);
        for (int i = 0; i < 512; i++) push_byte(8'(i));
        ref_model(511, -1);
        apply_stimulus(511, -1, 0);
        compare_logs("full_sector", m_done, m_code);
        if (wr_data_q.size() > 0) begin
            check_output("full_last_addr", 32'(wr_addr_q[wr_addr_q.size() - 1]), 32'd511);
            check_output("full_last_data", 32'(wr_data_q[wr_data_q.size() - 1]), 32'hFF);
        end

        // Randomized sectors against the reference model.
        for (int r = 0; r < 8; r++) begin
            bits_q.delete();
            len = int'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 7)) bits_q.push_back(1'b0);
                bits_q.push_back(1'b1);
            end
            repeat ($urandom_range(0, 12)) bits_q.push_back(1'b0);
            if ($urandom_range(0, 3) != 0) bits_q.push_back(1'b1);
            repeat ($urandom_range(0, len + 2)) push_byte(8'($urandom));
            drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, bits_q.size())) : -1;
            ref_model(len, drop);
            apply_stimulus(len, drop, 0);
            compare_logs($sformatf("rand%0d", r), m_done, m_code);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
